branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Branch prediction unit feeding the instruction fetch stage: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Combinational lookup on the current fetch PC produces btb_hit, predict_taken and predict_target.
- Resolution of conditional branches at EX/MEM produces bpu_correct and actual_taken, and updates the table synchronously.
- Keeps wrap-around branch and mispredict statistic counters for performance debug.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two.
- INDEX_BITS, 4, log2(BTB_ENTRIES).
- PC_WIDTH, 12, instruction address width.
- STAT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  PC_WIDTH  current fetch PC (lookup address).
- btb_hit  output  1  lookup entry valid and tag matches.
- predict_taken  output  1  btb_hit AND counter[1].
- predict_target  output  PC_WIDTH  stored target of the hit entry; 0 when no hit.
- ex_mem_branch  input  1  a conditional branch resolves this cycle.
- ex_mem_pc  input  PC_WIDTH  PC of the resolving branch.
- ex_mem_taken  input  1  branch outcome.
- ex_mem_branch_target  input  PC_WIDTH  computed branch target.
- ex_mem_pred_taken  input  1  prediction that was made for this branch, piped from IF.
- ex_mem_pred_target  input  PC_WIDTH  predicted target, piped from IF.
- bpu_correct  output  1  prediction matched the outcome.
- actual_taken  output  1  ex_mem_branch AND ex_mem_taken.
- stat_branches  output  STAT_WIDTH  resolved branch count.
- stat_mispredicts  output  STAT_WIDTH  mispredict count.

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2]; 6 bits at defaults.
  - Bits [1:0] are ignored.
- Entry contents: valid, tag, target[PC_WIDTH], ctr[2].
- Lookup:
  - Purely combinational from if_pc and the current table contents; zero-cycle latency.
  - predict_target is 0 when btb_hit=0.
- Correctness check (combinational):
  - ex_mem_branch=0: bpu_correct=1.
  - ex_mem_branch=1: bpu_correct = (ex_mem_pred_taken == ex_mem_taken) AND (!ex_mem_taken OR ex_mem_pred_target == ex_mem_branch_target).
- Update on the rising edge when ex_mem_branch=1, using index/tag of ex_mem_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target <= ex_mem_branch_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate; valid=1, tag written, target written, ctr=2 (weakly taken). Any conflicting entry is overwritten.
  - Miss, not taken: no allocation, no change.
- Statistics, on each ex_mem_branch=1 cycle:
  - stat_branches increments.
  - stat_mispredicts increments when bpu_correct=0.
  - Both wrap modulo 2^STAT_WIDTH.
- Reset (synchronous, active-high), applied at the rising edge:
  - All valid bits cleared.
  - All ctr set to 1 (weakly not taken).
  - All target and tag fields cleared.
  - Both stat counters cleared.
- Outputs after reset: btb_hit=0, predict_taken=0, predict_target=0. bpu_correct=1 and actual_taken=0 when ex_mem_branch=0.
- Boundary conditions:
  - Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. The new contents are visible from the next cycle.
  - Counter saturates at 3 and at 0; no wrap.
  - reset and ex_mem_branch in the same cycle: reset wins; no update, no stat increment.
  - Reset asserted mid-sequence: all history is lost; the next lookup misses.
  - Aliasing (same index, different tag): the entry misses. It is replaced only when the aliasing branch resolves taken.
  - JAL/JALR are not handled here; they must never assert ex_mem_branch.

Test Plan:
- Reset, then if_pc=0x040 -> btb_hit=0, predict_taken=0, predict_target=0x000; stat counters both 0.
- Resolve branch pc=0x040, taken, target 0x100, pred_taken=0 -> bpu_correct=0, actual_taken=1. Next cycle, if_pc=0x040 -> btb_hit=1, predict_taken=1, predict_target=0x100. stat_branches=1, stat_mispredicts=1.
- Same branch resolved not-taken twice with pred_taken=1 -> ctr goes 2 to 1 to 0; predict_taken=0 after the first update; btb_hit stays 1. Then resolved taken 4 times -> ctr saturates at 3 and does not wrap.
- Resolve pc=0x080, taken, target 0x200, pred_taken=1, pred_target=0x1F0 -> bpu_correct=0 (target mismatch); entry target becomes 0x200.
- Alias: pc=0x040 allocated, then pc=0x440 (same index 0, different tag) resolves taken to 0x300 -> lookup of 0x040 misses; lookup of 0x440 hits with target 0x300. A not-taken resolution of a missing alias allocates nothing.
- Same-cycle if_pc=0x040 and update to 0x040 -> btb_hit reflects old contents that cycle, new contents next cycle. Reset with ex_mem_branch=1 -> table cleared, stats stay 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters.
// Combinational lookup for fetch; synchronous update and statistics from EX/MEM.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   if_pc                  - fetch PC to look up
//   btb_hit                - entry valid and tag matches
//   predict_taken          - hit and counter says taken
//   predict_target         - stored target on hit, else 0
//   ex_mem_branch          - a conditional branch resolves this cycle
//   ex_mem_pc              - PC of the resolving branch
//   ex_mem_taken           - resolved direction
//   ex_mem_branch_target   - resolved target
//   ex_mem_pred_taken      - direction predicted at fetch
//   ex_mem_pred_target     - target predicted at fetch
//   bpu_correct            - prediction matched the resolution
//   actual_taken           - resolving branch was taken
//   stat_branches          - resolved branch count (wraps)
//   stat_mispredicts       - mispredict count (wraps)

module branch_predictor #(
    parameter int BTB_ENTRIES = 16,
    parameter int INDEX_BITS  = 4,
    parameter int PC_WIDTH    = 12,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  btb_hit,
    output logic                  predict_taken,
    output logic [PC_WIDTH-1:0]   predict_target,
    input  logic                  ex_mem_branch,
    input  logic [PC_WIDTH-1:0]   ex_mem_pc,
    input  logic                  ex_mem_taken,
    input  logic [PC_WIDTH-1:0]   ex_mem_branch_target,
    input  logic                  ex_mem_pred_taken,
    input  logic [PC_WIDTH-1:0]   ex_mem_pred_target,
    output logic                  bpu_correct,
    output logic                  actual_taken,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;

    // Table state
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] valid_d;
    logic [TAG_BITS-1:0]    tag_q    [BTB_ENTRIES];
    logic [TAG_BITS-1:0]    tag_d    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]    target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];

    // Statistics
    logic [STAT_WIDTH-1:0]  stat_branches_q;
    logic [STAT_WIDTH-1:0]  stat_branches_d;
    logic [STAT_WIDTH-1:0]  stat_mispredicts_q;
    logic [STAT_WIDTH-1:0]  stat_mispredicts_d;

    // Address split
    logic [INDEX_BITS-1:0]  lk_idx;
    logic [TAG_BITS-1:0]    lk_tag;
    logic [INDEX_BITS-1:0]  up_idx;
    logic [TAG_BITS-1:0]    up_tag;
    logic                   up_hit;
    logic                   dir_ok;
    logic                   tgt_ok;

    // Byte-offset bits carry no information for instruction addresses
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_mem_pc[1:0]};

    assign lk_idx = if_pc[INDEX_BITS+1:2];
    assign lk_tag = if_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign up_idx = ex_mem_pc[INDEX_BITS+1:2];
    assign up_tag = ex_mem_pc[PC_WIDTH-1:INDEX_BITS+2];

    // Lookup reads the registered table, so a same-cycle update is not seen
    always_comb begin
        btb_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken  = btb_hit && ctr_q[lk_idx][1];
        predict_target = btb_hit ? target_q[lk_idx] : '0;
    end

    // Resolution check; the target only matters for a taken branch
    always_comb begin
        dir_ok      = (ex_mem_pred_taken == ex_mem_taken);
        tgt_ok      = !ex_mem_taken ||
                      (ex_mem_pred_target == ex_mem_branch_target);
        bpu_correct = 1'b1;
        if (ex_mem_branch) begin
            bpu_correct = dir_ok && tgt_ok;
        end
    end

    assign actual_taken = ex_mem_branch & ex_mem_taken;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Next-state for the table and counters
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;

        if (ex_mem_branch) begin
            stat_branches_d = stat_branches_q + STAT_WIDTH'(1);
            if (!bpu_correct) begin
                stat_mispredicts_d = stat_mispredicts_q + STAT_WIDTH'(1);
            end

            if (up_hit) begin
                if (ex_mem_taken) begin
                    if (ctr_q[up_idx] != 2'd3) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = ex_mem_branch_target;
                end else begin
                    if (ctr_q[up_idx] != 2'd0) begin
                        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                    end
                end
            end else if (ex_mem_taken) begin
                // Allocate, evicting whatever aliased into this slot
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = ex_mem_branch_target;
                ctr_d[up_idx]    = 2'd2;
            end
        end
    end

    // Reset takes priority over any same-cycle resolution
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table,
// hand-written reset sequence, then random traffic against a table model.

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] if_pc;
    logic        btb_hit;
    logic        predict_taken;
    logic [11:0] predict_target;
    logic        br;
    logic [11:0] ex_pc;
    logic        tk;
    logic [11:0] tgt;
    logic        pt;
    logic [11:0] ptg;
    logic        bpu_correct;
    logic        actual_taken;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                  (clk),
        .reset                (rst),
        .if_pc                (if_pc),
        .btb_hit              (btb_hit),
        .predict_taken        (predict_taken),
        .predict_target       (predict_target),
        .ex_mem_branch        (br),
        .ex_mem_pc            (ex_pc),
        .ex_mem_taken         (tk),
        .ex_mem_branch_target (tgt),
        .ex_mem_pred_taken    (pt),
        .ex_mem_pred_target   (ptg),
        .bpu_correct          (bpu_correct),
        .actual_taken         (actual_taken),
        .stat_branches        (stat_branches),
        .stat_mispredicts     (stat_mispredicts)
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    typedef struct {
        logic [11:0] if_pc;
        logic        br;
        logic [11:0] pc;
        logic        tk;
        logic [11:0] tgt;
        logic        pt;
        logic [11:0] ptg;
        logic        hit;
        logic        ept;
        logic [11:0] etg;
        logic        cor;
        logic        act;
        int          sb;
        int          sm;
    } vec_t;

    function automatic vec_t mk(
        logic [11:0] a_if, logic a_br, logic [11:0] a_pc, logic a_tk,
        logic [11:0] a_tgt, logic a_pt, logic [11:0] a_ptg,
        logic e_hit, logic e_pt, logic [11:0] e_tg, logic e_cor,
        logic e_act, int e_sb, int e_sm);
        vec_t v;
        v.if_pc = a_if; v.br = a_br; v.pc = a_pc; v.tk = a_tk;
        v.tgt = a_tgt; v.pt = a_pt; v.ptg = a_ptg;
        v.hit = e_hit; v.ept = e_pt; v.etg = e_tg; v.cor = e_cor;
        v.act = e_act; v.sb = e_sb; v.sm = e_sm;
        return v;
    endfunction

    // Reference model: one record per slot, indexed by plain arithmetic on the PC
    bit mv  [16];
    int mtag[16];
    int mtg [16];
    int mc  [16];
    int msb;
    int msm;

    function automatic int slot(input int pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int tagof(input int pc);
        return pc / 64;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0; mtag[i] = 0; mtg[i] = 0; mc[i] = 1;
        end
        msb = 0;
        msm = 0;
    endtask

    function automatic int rnd_pc();
        int t, i;
        t = $urandom_range(0, 3);
        i = $urandom_range(0, 3);
        return t * 64 + i * 4 + $urandom_range(0, 3);
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1; if_pc = '0; br = 1'b0; ex_pc = '0; tk = 1'b0;
        tgt = '0; pt = 1'b0; ptg = '0;
        repeat (2) @(posedge clk);

        //         if_pc  br pc     tk tgt    pt ptg    hit pt tg     cor act sb  sm
        tbl.push_back(mk(12'h040,0,12'h000,0,12'h000,0,12'h000, 0,0,12'h000,1,0, 0, 0));
        tbl.push_back(mk(12'h040,1,12'h040,1,12'h100,0,12'h000, 0,0,12'h000,0,1, 0, 0));
        tbl.push_back(mk(12'h040,1,12'h040,0,12'h100,1,12'h100, 1,1,12'h100,0,0, 1, 1));
        tbl.push_back(mk(12'h040,1,12'h040,0,12'h100,1,12'h100, 1,0,12'h100,0,0, 2, 2));
        tbl.push_back(mk(12'h040,1,12'h040,1,12'h100,0,12'h000, 1,0,12'h100,0,1, 3, 3));
        tbl.push_back(mk(12'h040,1,12'h040,1,12'h100,0,12'h000, 1,0,12'h100,0,1, 4, 4));
        tbl.push_back(mk(12'h040,1,12'h040,1,12'h100,1,12'h100, 1,1,12'h100,1,1, 5, 5));
        tbl.push_back(mk(12'h040,1,12'h040,1,12'h100,1,12'h100, 1,1,12'h100,1,1, 6, 5));
        tbl.push_back(mk(12'h040,1,12'h040,0,12'h100,1,12'h100, 1,1,12'h100,0,0, 7, 5));
        tbl.push_back(mk(12'h040,0,12'h000,0,12'h000,0,12'h000, 1,1,12'h100,1,0, 8, 6));
        tbl.push_back(mk(12'h080,1,12'h080,1,12'h200,1,12'h1F0, 0,0,12'h000,0,1, 8, 6));
        tbl.push_back(mk(12'h080,0,12'h000,0,12'h000,0,12'h000, 1,1,12'h200,1,0, 9, 7));
        tbl.push_back(mk(12'h040,0,12'h000,0,12'h000,0,12'h000, 0,0,12'h000,1,0, 9, 7));
        tbl.push_back(mk(12'h440,1,12'h040,1,12'h100,0,12'h000, 0,0,12'h000,0,1, 9, 7));
        tbl.push_back(mk(12'h440,1,12'h440,1,12'h300,0,12'h000, 0,0,12'h000,0,1,10, 8));
        tbl.push_back(mk(12'h040,0,12'h000,0,12'h000,0,12'h000, 0,0,12'h000,1,0,11, 9));
        tbl.push_back(mk(12'h440,1,12'h040,0,12'h000,0,12'h000, 1,1,12'h300,1,0,11, 9));
        tbl.push_back(mk(12'h040,0,12'h000,0,12'h000,0,12'h000, 0,0,12'h000,1,0,12, 9));
        tbl.push_back(mk(12'h440,0,12'h000,0,12'h000,0,12'h000, 1,1,12'h300,1,0,12, 9));
        tbl.push_back(mk(12'h104,1,12'h104,1,12'h0F0,0,12'h000, 0,0,12'h000,0,1,12, 9));
        tbl.push_back(mk(12'h107,0,12'h000,0,12'h000,0,12'h000, 1,1,12'h0F0,1,0,13,10));

        foreach (tbl[k]) begin
            @(negedge clk);
            rst = 1'b0;
            if_pc = tbl[k].if_pc; br = tbl[k].br; ex_pc = tbl[k].pc;
            tk = tbl[k].tk; tgt = tbl[k].tgt; pt = tbl[k].pt; ptg = tbl[k].ptg;
            #1;
            chk("vec_hit", k, 32'(btb_hit), 32'(tbl[k].hit));
            chk("vec_pred_taken", k, 32'(predict_taken), 32'(tbl[k].ept));
            chk("vec_pred_target", k, 32'(predict_target), 32'(tbl[k].etg));
            chk("vec_correct", k, 32'(bpu_correct), 32'(tbl[k].cor));
            chk("vec_actual", k, 32'(actual_taken), 32'(tbl[k].act));
            chk("vec_stat_br", k, 32'(stat_branches), tbl[k].sb);
            chk("vec_stat_mis", k, 32'(stat_mispredicts), tbl[k].sm);
        end

        // Reset coinciding with a taken resolution: reset wins
        @(negedge clk);
        rst = 1'b1; br = 1'b1; ex_pc = 12'h104; tk = 1'b1;
        tgt = 12'h555; pt = 1'b0; ptg = '0; if_pc = 12'h104;
        #1;
        chk("rst_pre_hit", 0, 32'(btb_hit), 32'd1);
        @(negedge clk);
        rst = 1'b0; br = 1'b0; tk = 1'b0;
        #1;
        chk("rst_hit", 0, 32'(btb_hit), 32'd0);
        chk("rst_pred_taken", 0, 32'(predict_taken), 32'd0);
        chk("rst_target", 0, 32'(predict_target), 32'd0);
        chk("rst_stat_br", 0, 32'(stat_branches), 32'd0);
        chk("rst_stat_mis", 0, 32'(stat_mispredicts), 32'd0);
        chk("rst_correct", 0, 32'(bpu_correct), 32'd1);
        chk("rst_actual", 0, 32'(actual_taken), 32'd0);
        if_pc = 12'h440;
        #1;
        chk("rst_alias_hit", 0, 32'(btb_hit), 32'd0);

        // Random traffic against the model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int li, ui, ltag, utag;
            bit ehit, ept, ecor, eact;
            int etg;
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            if_pc = 12'(rnd_pc());
            br    = 1'($urandom_range(0, 1));
            ex_pc = 12'(rnd_pc());
            tk    = 1'($urandom_range(0, 1));
            tgt   = 12'($urandom_range(0, 3) * 256);
            ui    = slot(int'(ex_pc));
            utag  = tagof(int'(ex_pc));
            if ($urandom_range(0, 1) == 1) begin
                bit h;
                h   = mv[ui] && mtag[ui] == utag;
                pt  = h && mc[ui] >= 2;
                ptg = h ? 12'(mtg[ui]) : 12'h0;
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = 12'($urandom_range(0, 3) * 256);
            end
            #1;
            li   = slot(int'(if_pc));
            ltag = tagof(int'(if_pc));
            ehit = mv[li] && mtag[li] == ltag;
            ept  = ehit && mc[li] >= 2;
            etg  = ehit ? mtg[li] : 0;
            ecor = !br || (pt == tk && (!tk || ptg == tgt));
            eact = br && tk;
            chk("rnd_hit", c, 32'(btb_hit), 32'(ehit));
            chk("rnd_pred_taken", c, 32'(predict_taken), 32'(ept));
            chk("rnd_pred_target", c, 32'(predict_target), etg);
            chk("rnd_correct", c, 32'(bpu_correct), 32'(ecor));
            chk("rnd_actual", c, 32'(actual_taken), 32'(eact));
            chk("rnd_stat_br", c, 32'(stat_branches), msb);
            chk("rnd_stat_mis", c, 32'(stat_mispredicts), msm);

            if (rst) begin
                model_reset();
            end else if (br) begin
                msb = (msb + 1) % 65536;
                if (!ecor) msm = (msm + 1) % 65536;
                if (mv[ui] && mtag[ui] == utag) begin
                    if (tk) begin
                        mc[ui]  = (mc[ui] + 1 > 3) ? 3 : mc[ui] + 1;
                        mtg[ui] = int'(tgt);
                    end else begin
                        mc[ui] = (mc[ui] - 1 < 0) ? 0 : mc[ui] - 1;
                    end
                end else if (tk) begin
                    mv[ui]   = 1'b1;
                    mtag[ui] = utag;
                    mtg[ui]  = int'(tgt);
                    mc[ui]   = 2;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
